// File: rtl/sprite_bank.sv
// sprite_bank: bank of independently moving sprites with edge bounce and a
// one-cycle pixel cover pipeline (lowest active slot wins) for color_mapper.
module sprite_bank #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPRITE_W    = 32,
  parameter int unsigned SPRITE_H    = 32,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned AW          = 10
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic                   spawn_valid,
  input  logic [2:0]             spawn_id,
  input  logic [9:0]             spawn_x,
  input  logic [9:0]             spawn_y,
  input  logic [3:0]             spawn_dx,
  input  logic [3:0]             spawn_dy,
  input  logic                   kill_valid,
  input  logic [2:0]             kill_id,
  input  logic                   freeze,
  output logic                   frame_tick,
  output logic [NUM_SPRITES-1:0] active,
  output logic                   hit,
  output logic [2:0]             hit_id,
  output logic [AW-1:0]          sprite_addr
);

  localparam int unsigned MAX_X = SCREEN_W - SPRITE_W;
  localparam int unsigned MAX_Y = SCREEN_H - SPRITE_H;
  localparam logic signed [10:0] MAX_XS = 11'(MAX_X);
  localparam logic signed [10:0] MAX_YS = 11'(MAX_Y);

  logic [9:0]        pos_x [NUM_SPRITES];
  logic [9:0]        pos_y [NUM_SPRITES];
  logic signed [4:0] vel_x [NUM_SPRITES];
  logic signed [4:0] vel_y [NUM_SPRITES];

  logic signed [10:0] nx [NUM_SPRITES];
  logic signed [10:0] ny [NUM_SPRITES];
  logic               bounce_x [NUM_SPRITES];
  logic               bounce_y [NUM_SPRITES];

  logic [9:0] spawn_x_cl;
  logic [9:0] spawn_y_cl;

  logic          frame_s1, frame_s2, frame_q;
  logic          hit_c;
  logic [2:0]    hit_id_c;
  logic [AW-1:0] addr_c;

  // frame_clk is asynchronous: two-flop synchroniser, then rising-edge detect
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_s1   <= 1'b0;
      frame_s2   <= 1'b0;
      frame_q    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_s1   <= frame_clk;
      frame_s2   <= frame_s1;
      frame_q    <= frame_s2;
      frame_tick <= frame_s2 & ~frame_q;
    end
  end

  // Candidate next positions and bounce decisions, signed 11-bit per axis
  always_comb begin
    for (int i = 0; i < int'(NUM_SPRITES); i++) begin
      nx[i]       = signed'({1'b0, pos_x[i]}) + 11'(vel_x[i]);
      ny[i]       = signed'({1'b0, pos_y[i]}) + 11'(vel_y[i]);
      bounce_x[i] = (nx[i] < 11'sd0) || (nx[i] > MAX_XS);
      bounce_y[i] = (ny[i] < 11'sd0) || (ny[i] > MAX_YS);
    end
  end

  assign spawn_x_cl = (spawn_x > 10'(MAX_X)) ? 10'(MAX_X) : spawn_x;
  assign spawn_y_cl = (spawn_y > 10'(MAX_Y)) ? 10'(MAX_Y) : spawn_y;

  // Slot state: kill beats spawn, both beat frame motion for that slot
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        vel_x[i] <= '0;
        vel_y[i] <= '0;
      end
      active <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        if (kill_valid && (kill_id == 3'(i))) begin
          active[i] <= 1'b0;
        end else if (spawn_valid && (spawn_id == 3'(i))) begin
          pos_x[i]  <= spawn_x_cl;
          pos_y[i]  <= spawn_y_cl;
          vel_x[i]  <= {spawn_dx[3], spawn_dx};
          vel_y[i]  <= {spawn_dy[3], spawn_dy};
          active[i] <= 1'b1;
        end else if (frame_tick && active[i] && !freeze) begin
          if (bounce_x[i]) vel_x[i] <= -vel_x[i];
          else             pos_x[i] <= nx[i][9:0];
          if (bounce_y[i]) vel_y[i] <= -vel_y[i];
          else             pos_y[i] <= ny[i][9:0];
        end
      end
    end
  end

  // Cover search from the top down so the lowest active index is left standing
  always_comb begin
    hit_c    = 1'b0;
    hit_id_c = '0;
    addr_c   = '0;
    for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
      if (active[i] &&
          (DrawX >= pos_x[i]) && (11'(DrawX) < 11'(pos_x[i]) + 11'(SPRITE_W)) &&
          (DrawY >= pos_y[i]) && (11'(DrawY) < 11'(pos_y[i]) + 11'(SPRITE_H))) begin
        hit_c    = 1'b1;
        hit_id_c = 3'(i);
        addr_c   = AW'((32'(DrawY - pos_y[i]) * SPRITE_W) + 32'(DrawX - pos_x[i]));
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit         <= 1'b0;
      hit_id      <= '0;
      sprite_addr <= '0;
    end else begin
      hit         <= hit_c;
      hit_id      <= hit_id_c;
      sprite_addr <= addr_c;
    end
  end

endmodule

// File: tb/tb_sprite_bank.sv
// Directed bench for sprite_bank: reset, motion, bounce, clamp, priority,
// kill/spawn collisions, frame_tick timing and freeze.
module tb_sprite_bank;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic [9:0] DrawX, DrawY;
  logic       spawn_valid;
  logic [2:0] spawn_id;
  logic [9:0] spawn_x, spawn_y;
  logic [3:0] spawn_dx, spawn_dy;
  logic       kill_valid;
  logic [2:0] kill_id;
  logic       freeze;
  logic       frame_tick;
  logic [3:0] active;
  logic       hit;
  logic [2:0] hit_id;
  logic [9:0] sprite_addr;

  int checks   = 0;
  int failures = 0;
  int pulses;
  int first_k;

  sprite_bank dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY),
    .spawn_valid(spawn_valid), .spawn_id(spawn_id),
    .spawn_x(spawn_x), .spawn_y(spawn_y),
    .spawn_dx(spawn_dx), .spawn_dy(spawn_dy),
    .kill_valid(kill_valid), .kill_id(kill_id), .freeze(freeze),
    .frame_tick(frame_tick), .active(active), .hit(hit),
    .hit_id(hit_id), .sprite_addr(sprite_addr)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic spawn(input logic [2:0] id, input logic [9:0] x, input logic [9:0] y,
                       input logic [3:0] dx, input logic [3:0] dy);
    spawn_valid = 1'b1; spawn_id = id; spawn_x = x; spawn_y = y;
    spawn_dx = dx; spawn_dy = dy;
    tick();
    spawn_valid = 1'b0;
  endtask

  task automatic kill(input logic [2:0] id);
    kill_valid = 1'b1; kill_id = id;
    tick();
    kill_valid = 1'b0;
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    repeat (6) tick();
    frame_clk = 1'b0;
    repeat (4) tick();
  endtask

  // Present a pixel, then check the registered result one cycle later
  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic eh, input logic [2:0] eid, input logic [9:0] ea);
    DrawX = x; DrawY = y;
    tick();
    chk({tag, ".hit"}, 32'(hit), 32'(eh));
    chk({tag, ".id"}, 32'(hit_id), 32'(eid));
    chk({tag, ".addr"}, 32'(sprite_addr), 32'(ea));
  endtask

  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0; DrawX = '0; DrawY = '0;
    spawn_valid = 1'b0; spawn_id = '0; spawn_x = '0; spawn_y = '0;
    spawn_dx = '0; spawn_dy = '0; kill_valid = 1'b0; kill_id = '0; freeze = 1'b0;
    repeat (3) tick();
    chk("rst.active", 32'(active), 32'd0);
    chk("rst.hit", 32'(hit), 32'd0);
    chk("rst.tick", 32'(frame_tick), 32'd0);
    Reset_n = 1'b1;
    tick();

    // Spawn slot 0 and an out-of-range id
    spawn(3'd0, 10'd100, 10'd50, 4'sd3, -4'sd2);
    spawn(3'd5, 10'd10, 10'd10, 4'd0, 4'd0);
    chk("spawn.active", 32'(active), 32'd1);
    probe("s0.origin", 10'd100, 10'd50, 1'b1, 3'd0, 10'd0);
    probe("s0.inner", 10'd101, 10'd51, 1'b1, 3'd0, 10'd33);

    // Two frames: (106,46); edge-of-box checks
    frame();
    frame();
    probe("f2.origin", 10'd106, 10'd46, 1'b1, 3'd0, 10'd0);
    probe("f2.left", 10'd105, 10'd46, 1'b0, 3'd0, 10'd0);
    probe("f2.rightin", 10'd137, 10'd46, 1'b1, 3'd0, 10'd31);
    probe("f2.rightout", 10'd138, 10'd46, 1'b0, 3'd0, 10'd0);
    probe("f2.bottomin", 10'd106, 10'd77, 1'b1, 3'd0, 10'd992);
    probe("f2.bottomout", 10'd106, 10'd78, 1'b0, 3'd0, 10'd0);

    // Right-edge bounce on slot 1 (MAX_X = 608)
    spawn(3'd1, 10'd600, 10'd200, 4'sd5, 4'd0);
    frame();
    probe("b1.605", 10'd605, 10'd200, 1'b1, 3'd1, 10'd0);
    probe("b1.604", 10'd604, 10'd200, 1'b0, 3'd0, 10'd0);
    frame();
    probe("b2.hold", 10'd605, 10'd200, 1'b1, 3'd1, 10'd0);
    probe("b2.edgeout", 10'd637, 10'd200, 1'b0, 3'd0, 10'd0);
    frame();
    probe("b3.600", 10'd600, 10'd200, 1'b1, 3'd1, 10'd0);
    probe("b3.599", 10'd599, 10'd200, 1'b0, 3'd0, 10'd0);
    probe("s0.f5", 10'd115, 10'd40, 1'b1, 3'd0, 10'd0);

    // Spawn clamping, then kill
    spawn(3'd3, 10'd700, 10'd479, 4'd0, 4'd0);
    probe("clamp.origin", 10'd608, 10'd448, 1'b1, 3'd3, 10'd0);
    probe("clamp.corner", 10'd639, 10'd479, 1'b1, 3'd3, 10'd1023);
    kill(3'd3);
    chk("kill3.active", 32'(active), 32'b0011);
    probe("kill3.gone", 10'd608, 10'd448, 1'b0, 3'd0, 10'd0);

    // Overlap priority
    spawn(3'd0, 10'd100, 10'd50, 4'd0, 4'd0);
    spawn(3'd2, 10'd110, 10'd55, 4'sd2, 4'd0);
    probe("ovl.id0", 10'd120, 10'd60, 1'b1, 3'd0, 10'd340);
    kill(3'd0);
    probe("ovl.id2", 10'd120, 10'd60, 1'b1, 3'd2, 10'd170);
    chk("ovl.active", 32'(active), 32'b0110);

    // Kill + spawn of slot 2 on the frame_tick cycle
    frame_clk = 1'b1;
    tick();
    tick();
    chk("ft.early", 32'(frame_tick), 32'd0);
    tick();
    chk("ft.on", 32'(frame_tick), 32'd1);
    spawn_valid = 1'b1; spawn_id = 3'd2; spawn_x = 10'd300; spawn_y = 10'd300;
    kill_valid = 1'b1; kill_id = 3'd2;
    tick();
    spawn_valid = 1'b0; kill_valid = 1'b0;
    chk("ft.off", 32'(frame_tick), 32'd0);
    frame_clk = 1'b0;
    repeat (4) tick();
    chk("sk.active", 32'(active), 32'b0010);
    probe("sk.s1moved", 10'd595, 10'd200, 1'b1, 3'd1, 10'd0);
    probe("sk.noload", 10'd300, 10'd300, 1'b0, 3'd0, 10'd0);

    // Long frame_clk level with freeze: one pulse, no motion
    freeze = 1'b1;
    pulses = 0; first_k = 0;
    frame_clk = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (frame_tick) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
    end
    frame_clk = 1'b0;
    repeat (4) tick();
    freeze = 1'b0;
    chk("level.pulses", 32'(pulses), 32'd1);
    chk("level.latency", 32'(first_k), 32'd3);
    probe("frz.hold", 10'd595, 10'd200, 1'b1, 3'd1, 10'd0);
    frame();
    probe("unfrz.590", 10'd590, 10'd200, 1'b1, 3'd1, 10'd0);

    // Asynchronous reset mid-frame with two slots active
    spawn(3'd0, 10'd10, 10'd10, 4'sd1, 4'sd1);
    chk("pre.active", 32'(active), 32'b0011);
    probe("pre.hit", 10'd590, 10'd200, 1'b1, 3'd1, 10'd0);
    frame_clk = 1'b1;
    tick();
    tick();
    #2 Reset_n = 1'b0;
    #1;
    chk("arst.hit", 32'(hit), 32'd0);
    chk("arst.id", 32'(hit_id), 32'd0);
    chk("arst.active", 32'(active), 32'd0);
    chk("arst.tick", 32'(frame_tick), 32'd0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    frame_clk = 1'b0;
    tick();
    chk("post.active", 32'(active), 32'd0);
    chk("post.hit", 32'(hit), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
